cpu_step_controller: RTL and testbench
======================================

# cpu_step_controller

Run/single-step controller directly downstream of the board clock divider. Runs on the fast board clock, detects rising edges of the divided slow clock and turns them into one-cycle processor clock-enable pulses (`Cpu_Tick`) according to a Run/Step switch, a debounced step push-button and the processor's halt request. It also counts issued processor cycles for the board display.

## Interface
Parameters:
- `DEBOUNCE_COUNT`, default 50000: consecutive Fast_Clock samples a button level must differ from the debounced level before it is accepted; minimum 2.
- `COUNT_WIDTH`, default 32: width of `Cycle_Count`.

Ports:
- `Fast_Clock`  in  1  board clock; the only clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Slow_Clock`  in  1  divided clock from the clock divider, already synchronous to `Fast_Clock`; reset level 1.
- `Run_Mode`  in  1  raw switch; 1 = free run, 0 = single step.
- `Step_Button`  in  1  raw push-button, active-high, bouncing.
- `Halt`  in  1  processor halt request, synchronous to `Fast_Clock`.
- `Cpu_Tick`  out  1  processor clock enable; registered one-cycle pulse.
- `Halted`  out  1  high while in HALT.
- `Cycle_Count`  out  COUNT_WIDTH  number of `Cpu_Tick` pulses issued since reset.

## Operation
- Input conditioning: `Run_Mode` and `Step_Button` each pass through a 2-flop synchronizer (`run_s`, `btn_s`).
- Debouncer on `btn_s`: counter clears whenever `btn_s` equals the debounced level `btn_d`, otherwise increments; after the `DEBOUNCE_COUNT`-th consecutive differing sample, `btn_d <= btn_s` and the counter clears. `press` = one-cycle pulse on the `btn_d` 0→1 transition. Release produces no event.
- Edge detect: register `slow_prev`; `slow_edge = Slow_Clock & ~slow_prev`.
- FSM (reset state STEP):
  - STEP: `press` sets `pending` (at most one; further presses while pending are ignored). On `slow_edge` with `pending`, issue a tick and clear `pending`. `Halt` → HALT (clear `pending`). Else `run_s` = 1 → RUN (clear `pending`).
  - RUN: tick on every `slow_edge`. `Halt` → HALT. Else `run_s` = 0 → STEP with `pending` = 0. `press` is ignored.
  - HALT: no ticks; `Halted` = 1. `press` → RUN if `run_s`, else STEP. The press is consumed and does not set `pending`.
- Priority within a cycle: Reset > `Halt` > `slow_edge` tick > mode change. If `Halt` and `slow_edge` coincide, no tick is issued.
- `Cycle_Count` increments by 1 on each issued tick and wraps from all-ones to 0.

## Timing
- Reset values: `Cpu_Tick` = 0, `Halted` = 0, `Cycle_Count` = 0, state = STEP, `pending` = 0, `slow_prev` = 1, synchronizers = 0, `btn_d` = 0, debounce counter = 0. `slow_prev` = 1 prevents a spurious edge when the divider also leaves reset at 1.
- Tick latency: `slow_edge` is seen in cycle N; `Cpu_Tick` is high in cycle N+1 only. `Cycle_Count` shows the new value from cycle N+1.
- Button latency: a clean press reaches `btn_s` after 2 cycles, then `btn_d` after `DEBOUNCE_COUNT` further cycles. `press` is high the cycle after `btn_d` rises.
- `press` and `slow_edge` in the same STEP cycle: `pending` is set but no tick yet; the tick comes on the next edge.
- `Halted` is registered and asserts in the cycle after the `Halt` sample. It deasserts in the cycle after the consuming `press`.
- Reset mid-operation: all state returns to reset values on the next edge. A pending step is lost and no tick is emitted in the reset cycle.

## Test plan
Bench uses `DEBOUNCE_COUNT` = 4 and `Slow_Clock` toggling every 3 cycles.
- Reset then RUN: `Run_Mode` = 1, 10 `Slow_Clock` rising edges → exactly 10 `Cpu_Tick` pulses, each one cycle wide, each 1 cycle after its edge; `Cycle_Count` = 10.
- Step with bounce: `Run_Mode` = 0; `Step_Button` toggles 1,0,1 on single cycles, then holds 1 for 20 cycles → exactly one tick, on the first `slow_edge` after `press`; `Cycle_Count` = 1. A second press while `pending` still yields only one tick.
- Halt: in RUN, assert `Halt` for 1 cycle coincident with `slow_edge` → no tick; `Halted` = 1 on the next cycle; no ticks over 20 further edges. One press with `Run_Mode` = 1 → `Halted` = 0 and ticks resume on the next edge.
- Mode switch: RUN → `Run_Mode` = 0 → ticks stop within 3 cycles of the switch (sync + 1); a step press then gives exactly one tick.
- Wrap: `COUNT_WIDTH` = 4, 17 ticks → `Cycle_Count` reads 15 then 0 then 1.
- Reset mid-step: set `pending`, assert `Reset` for 1 cycle before the next edge → no tick, all outputs 0, state STEP.

Source files
------------

// File: rtl/cpu_step_controller.sv
// Run/single-step controller: converts rising edges of the divided slow clock into
// one-cycle processor clock enables, gated by run/step mode, a debounced step button and halt.
module cpu_step_controller #(
    parameter int DEBOUNCE_COUNT = 50000,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   Fast_Clock,
    input  logic                   Reset,
    input  logic                   Slow_Clock,
    input  logic                   Run_Mode,
    input  logic                   Step_Button,
    input  logic                   Halt,
    output logic                   Cpu_Tick,
    output logic                   Halted,
    output logic [COUNT_WIDTH-1:0] Cycle_Count
);

    localparam int DBW = $clog2(DEBOUNCE_COUNT);

    typedef enum logic [1:0] {
        S_STEP = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    logic                   r_run_meta, r_run_s;
    logic                   r_btn_meta, r_btn_s;
    logic                   r_btn_d, r_btn_d_q;
    logic [DBW-1:0]         r_db_cnt;
    logic                   r_slow_prev;
    state_t                 r_state;
    logic                   r_pending;
    logic                   r_tick;
    logic                   r_halted;
    logic [COUNT_WIDTH-1:0] r_count;

    state_t                 w_state_next;
    logic                   w_pending_next;
    logic                   w_tick;
    logic                   w_press;
    logic                   w_slow_edge;

    assign w_press     = r_btn_d & ~r_btn_d_q;
    assign w_slow_edge = Slow_Clock & ~r_slow_prev;

    always_ff @(posedge Fast_Clock) begin
        if (Reset) begin
            r_run_meta  <= 1'b0;
            r_run_s     <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_s     <= 1'b0;
            r_btn_d     <= 1'b0;
            r_btn_d_q   <= 1'b0;
            r_db_cnt    <= '0;
            r_slow_prev <= 1'b1;
        end else begin
            r_run_meta  <= Run_Mode;
            r_run_s     <= r_run_meta;
            r_btn_meta  <= Step_Button;
            r_btn_s     <= r_btn_meta;
            r_btn_d_q   <= r_btn_d;
            r_slow_prev <= Slow_Clock;
            // Accept a new level only after DEBOUNCE_COUNT consecutive differing samples.
            if (r_btn_s == r_btn_d) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DBW'(DEBOUNCE_COUNT - 1)) begin
                r_btn_d  <= r_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_tick         = 1'b0;
        case (r_state)
            S_STEP: begin
                if (Halt) begin
                    w_state_next   = S_HALT;
                    w_pending_next = 1'b0;
                end else begin
                    if (w_slow_edge && r_pending) begin
                        w_tick         = 1'b1;
                        w_pending_next = 1'b0;
                    end else if (w_press) begin
                        w_pending_next = 1'b1;
                    end
                    if (r_run_s) begin
                        w_state_next   = S_RUN;
                        w_pending_next = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (Halt) begin
                    w_state_next = S_HALT;
                end else begin
                    w_tick = w_slow_edge;
                    if (!r_run_s) begin
                        w_state_next   = S_STEP;
                        w_pending_next = 1'b0;
                    end
                end
            end
            S_HALT: begin
                // The releasing press is consumed here and never becomes a pending step.
                if (!Halt && w_press) begin
                    w_state_next   = r_run_s ? S_RUN : S_STEP;
                    w_pending_next = 1'b0;
                end
            end
            default: begin
                w_state_next   = S_STEP;
                w_pending_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Fast_Clock) begin
        if (Reset) begin
            r_state   <= S_STEP;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_halted  <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_tick    <= w_tick;
            r_halted  <= (w_state_next == S_HALT);
            if (w_tick) begin
                r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign Cpu_Tick    = r_tick;
    assign Halted      = r_halted;
    assign Cycle_Count = r_count;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed scenarios plus random stimulus, checked every
// cycle against a cycle-level behavioural model, with literal expectations at key points.
module tb_cpu_step_controller;

    localparam int DB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Slow_Clock = 1'b1;
    logic          Run_Mode = 1'b0;
    logic          Step_Button = 1'b0;
    logic          Halt = 1'b0;
    logic          Cpu_Tick;
    logic          Halted;
    logic [CW-1:0] Cycle_Count;

    cpu_step_controller #(.DEBOUNCE_COUNT(DB), .COUNT_WIDTH(CW)) dut (
        .Fast_Clock (clk),
        .Reset      (Reset),
        .Slow_Clock (Slow_Clock),
        .Run_Mode   (Run_Mode),
        .Step_Button(Step_Button),
        .Halt       (Halt),
        .Cpu_Tick   (Cpu_Tick),
        .Halted     (Halted),
        .Cycle_Count(Cycle_Count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Slow clock generator: toggles every 3 cycles, never rises past slow_limit.
    bit slow_en = 0;
    int slow_limit = 0;
    int edges_gen = 0;
    int ph = 0;
    bit rise_now = 0;
    always @(posedge clk) begin
        #2;
        rise_now = 0;
        if (slow_en) begin
            ph = ph + 1;
            if (ph >= 3) begin
                ph = 0;
                if (Slow_Clock) Slow_Clock = 1'b0;
                else if (edges_gen < slow_limit) begin
                    Slow_Clock = 1'b1;
                    edges_gen  = edges_gen + 1;
                    rise_now   = 1;
                end
            end
        end
    end

    // Behavioural model: inputs seen through 2-sample delay lines, a run-length debounce,
    // and the three operating modes (0 step, 1 run, 2 halt).
    bit          model_ok = 0;
    bit          m_run1, m_run_s, m_btn1, m_btn_s, m_btn_d, m_rose, m_slow_prev, m_pend;
    int          m_diff, m_mode;
    bit          exp_tick, exp_halted;
    logic [CW-1:0] exp_count;

    always @(posedge clk) begin
        bit sedge, press, tick, npend;
        int nmode;
        if (Reset) begin
            m_run1 = 0; m_run_s = 0; m_btn1 = 0; m_btn_s = 0; m_btn_d = 0;
            m_rose = 0; m_slow_prev = 1; m_pend = 0; m_diff = 0; m_mode = 0;
            exp_tick = 0; exp_halted = 0; exp_count = '0;
            model_ok = 1;
        end else begin
            sedge = Slow_Clock && !m_slow_prev;
            press = m_rose;
            tick  = 0;
            nmode = m_mode;
            npend = m_pend;
            if (m_mode == 0) begin
                if (Halt) begin nmode = 2; npend = 0; end
                else begin
                    if (sedge && m_pend) begin tick = 1; npend = 0; end
                    else if (press) npend = 1;
                    if (m_run_s) begin nmode = 1; npend = 0; end
                end
            end else if (m_mode == 1) begin
                if (Halt) nmode = 2;
                else begin
                    tick = sedge;
                    if (!m_run_s) begin nmode = 0; npend = 0; end
                end
            end else begin
                if (!Halt && press) begin nmode = m_run_s ? 1 : 0; npend = 0; end
            end
            m_slow_prev = Slow_Clock;
            m_rose = 0;
            if (m_btn_s == m_btn_d) m_diff = 0;
            else if (m_diff + 1 == DB) begin
                m_btn_d = m_btn_s; m_diff = 0; m_rose = m_btn_s;
            end else m_diff = m_diff + 1;
            m_btn_s = m_btn1; m_btn1 = Step_Button;
            m_run_s = m_run1; m_run1 = Run_Mode;
            m_mode = nmode; m_pend = npend;
            exp_tick = tick;
            exp_halted = (nmode == 2);
            exp_count = exp_count + CW'(tick);
        end
    end

    int ticks_seen = 0;
    always @(negedge clk) begin
        if (Cpu_Tick === 1'b1) ticks_seen++;
        if (model_ok) begin
            check("model_tick", int'(Cpu_Tick), int'(exp_tick));
            check("model_halted", int'(Halted), int'(exp_halted));
            check("model_count", int'(Cycle_Count), int'(exp_count));
        end
    end

    task automatic wait_edges(input int n);
        int target;
        target = edges_gen + n;
        slow_limit = target;
        slow_en = 1;
        for (int k = 0; k < 10 * n + 20 && edges_gen < target; k++) @(negedge clk);
        if (edges_gen < target) check("edge_timeout", edges_gen, target);
        repeat (2) @(negedge clk);
    endtask

    task automatic quiesce();
        slow_limit = edges_gen;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_btn();
        Step_Button = 1'b1;
        repeat (8) @(negedge clk);
        Step_Button = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int hold;
        int e0;
        bit found;
        repeat (3) @(negedge clk);
        check("reset_tick", int'(Cpu_Tick), 0);
        check("reset_halted", int'(Halted), 0);
        check("reset_count", int'(Cycle_Count), 0);
        Reset = 1'b0;

        // Free run: 10 edges -> 10 ticks.
        Run_Mode = 1'b1;
        repeat (4) @(negedge clk);
        ticks_seen = 0;
        wait_edges(10);
        check("run_ticks", ticks_seen, 10);
        check("run_count", int'(Cycle_Count), 10);

        // Single step with a bouncing button.
        Run_Mode = 1'b0;
        repeat (4) @(negedge clk);
        ticks_seen = 0;
        slow_limit = edges_gen + 100;
        Step_Button = 1'b1; @(negedge clk);
        Step_Button = 1'b0; @(negedge clk);
        Step_Button = 1'b1;
        repeat (21) @(negedge clk);
        repeat (20) @(negedge clk);
        Step_Button = 1'b0;
        repeat (20) @(negedge clk);
        quiesce();
        check("step_bounce_ticks", ticks_seen, 1);
        check("step_bounce_count", int'(Cycle_Count), 11);

        // Two presses while the slow clock is stopped: still one tick.
        ticks_seen = 0;
        press_btn();
        press_btn();
        check("step_pending_noedge", ticks_seen, 0);
        wait_edges(3);
        check("step_double_ticks", ticks_seen, 1);
        check("step_double_count", int'(Cycle_Count), 12);

        // Halt coincident with an edge.
        Run_Mode = 1'b1;
        repeat (4) @(negedge clk);
        slow_limit = edges_gen + 200;
        slow_en = 1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (rise_now) found = 1;
        end
        check("halt_find_edge", int'(found), 1);
        ticks_seen = 0;
        Halt = 1'b1;
        @(negedge clk);
        Halt = 1'b0;
        check("halt_asserted", int'(Halted), 1);
        e0 = edges_gen;
        for (int k = 0; k < 200 && edges_gen < e0 + 20; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("halt_no_ticks", ticks_seen, 0);
        check("halt_held", int'(Halted), 1);
        quiesce();
        press_btn();
        check("halt_released", int'(Halted), 0);
        ticks_seen = 0;
        wait_edges(3);
        check("halt_resume_ticks", ticks_seen, 3);

        // Run -> step mode switch.
        slow_limit = edges_gen + 200;
        repeat (10) @(negedge clk);
        Run_Mode = 1'b0;
        repeat (3) @(negedge clk);
        ticks_seen = 0;
        repeat (30) @(negedge clk);
        check("switch_ticks_stop", ticks_seen, 0);
        quiesce();
        press_btn();
        wait_edges(3);
        check("switch_step_ticks", ticks_seen, 1);

        // Counter wrap at 4 bits.
        Reset = 1'b1; @(negedge clk); Reset = 1'b0;
        Run_Mode = 1'b1;
        repeat (4) @(negedge clk);
        wait_edges(15);
        check("wrap_15", int'(Cycle_Count), 15);
        wait_edges(1);
        check("wrap_0", int'(Cycle_Count), 0);
        wait_edges(1);
        check("wrap_1", int'(Cycle_Count), 1);

        // Reset with a step pending.
        Run_Mode = 1'b0;
        repeat (4) @(negedge clk);
        quiesce();
        press_btn();
        Reset = 1'b1;
        @(negedge clk);
        check("rst_mid_tick", int'(Cpu_Tick), 0);
        check("rst_mid_halted", int'(Halted), 0);
        check("rst_mid_count", int'(Cycle_Count), 0);
        Reset = 1'b0;
        ticks_seen = 0;
        wait_edges(3);
        check("rst_mid_pending_lost", ticks_seen, 0);

        // Random stimulus against the model.
        slow_limit = edges_gen + 100000;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom % 150 == 0) Run_Mode = ~Run_Mode;
            Halt = ($urandom % 80 == 0);
            hold = hold - 1;
            if (hold <= 0) begin
                Step_Button = 1'($urandom % 2);
                hold = $urandom_range(1, 10);
            end
        end
        Halt = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
